// File: rtl/fft_frame_ctrl_pkg.sv
// Shared definitions for fft_frame_ctrl.
// FFT_FRAME_CTRL_ZPAD_EN adds the PAD state that zero-fills short frames.
package fft_frame_ctrl_pkg;

  localparam int CFG_W           = 8;
  localparam int CFG_LOG2_LSB    = 0;
  localparam int CFG_LOG2_W      = 5;
  localparam int CFG_INV_BIT     = 5;
  localparam int MIN_LOG2_POINTS = 3;

  localparam int BIN_W   = 16;
  localparam int TUSER_W = 24;

  localparam int ALM_W     = 3;
  localparam int ALM_EARLY = 0;
  localparam int ALM_MISS  = 1;
  localparam int ALM_CORE  = 2;

`ifdef FFT_FRAME_CTRL_ZPAD_EN
  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    RUN   = 2'd1,
    PAD   = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    RUN   = 2'd1
  } state_e;
`endif

  // N-1 for a given log2(N); log2(N)=16 wraps to 16'hFFFF.
  function automatic logic [BIN_W-1:0] bin_limit(
    input logic [CFG_LOG2_W-1:0] log2n
  );
    logic [BIN_W:0] n;
    n = (BIN_W+1)'(1) << log2n;
    return n[BIN_W-1:0] - BIN_W'(1);
  endfunction

endpackage

// File: rtl/fft_bin_counter.sv
// Wrapping bin counter with a runtime N-1 limit.
// Shared by the input and output sides of fft_frame_ctrl.
module fft_bin_counter
  import fft_frame_ctrl_pkg::*;
(
  input  logic             i_aclk,
  input  logic             i_aresetn,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [BIN_W-1:0] i_lim,
  output logic [BIN_W-1:0] o_cnt,
  output logic             o_last
);

  assign o_last = (o_cnt == i_lim);

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      o_cnt <= '0;
    end else if (i_clr) begin
      o_cnt <= '0;
    end else if (i_en) begin
      o_cnt <= o_last ? '0 : o_cnt + BIN_W'(1);
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame controller between an AXI4-Stream source and a streaming FFT core.
// Optional zero padding of short frames: FFT_FRAME_CTRL_ZPAD_EN.
module fft_frame_ctrl
  import fft_frame_ctrl_pkg::*;
#(
  parameter int DATAIN_WIDTH    = 16,
  parameter int DATAOUT_WIDTH   = 16,
  parameter int MAX_LOG2_POINTS = 10,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                       i_aclk,
  input  logic                       i_aresetn,
  input  logic                       i_axi4s_cfg_tvalid,
  input  logic [CFG_W-1:0]           i_axi4s_cfg_tdata,
  output logic                       o_axi4s_cfg_tready,
  input  logic                       i_axi4s_data_tvalid,
  input  logic [2*DATAIN_WIDTH-1:0]  i_axi4s_data_tdata,
  input  logic                       i_axi4s_data_tlast,
  output logic                       o_axi4s_data_tready,
  output logic                       o_core_cfg_tvalid,
  output logic [CFG_W-1:0]           o_core_cfg_tdata,
  output logic                       o_core_tvalid,
  output logic [2*DATAOUT_WIDTH-1:0] o_core_tdata,
  output logic                       o_core_tlast,
  input  logic                       i_core_tready,
  input  logic                       i_core_tvalid,
  input  logic [2*DATAOUT_WIDTH-1:0] i_core_tdata,
  input  logic                       i_core_tlast,
  output logic                       o_axi4s_data_tvalid,
  output logic [2*DATAOUT_WIDTH-1:0] o_axi4s_data_tdata,
  output logic                       o_axi4s_data_tlast,
  output logic [TUSER_W-1:0]         o_axi4s_data_tuser,
  output logic [ALM_W-1:0]           o_alm,
  output logic                       o_stat
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] OMAX = OW'(MAX_OUTSTANDING);

  state_e state_q, state_d;

  logic [CFG_W-1:0]  cfg_q;
  logic [OW-1:0]     outst_q;
  logic [ALM_W-1:0]  alm_q, alm_set;
  logic              stat_q, cfg_pulse_q;

  logic [BIN_W-1:0]  lim, in_cnt, out_cnt;
  logic              in_last, out_last;

  logic              run, pad;
  logic              cfg_tready, data_tready, core_tvalid;
  logic              cfg_hs, cfg_legal, cfg_ok;
  logic              stall, in_beat, run_hs, in_end;
  logic              out_beat, out_end;
  logic [CFG_LOG2_W-1:0] cfg_log;

  logic [DATAOUT_WIDTH-1:0] ext_i, ext_q;

  logic                       dv_q, dl_q;
  logic [2*DATAOUT_WIDTH-1:0] dd_q;
  logic [TUSER_W-1:0]         du_q;

  assign lim     = bin_limit(cfg_q[CFG_LOG2_LSB +: CFG_LOG2_W]);
  assign cfg_log = i_axi4s_cfg_tdata[CFG_LOG2_LSB +: CFG_LOG2_W];

  assign cfg_legal = (cfg_log >= CFG_LOG2_W'(MIN_LOG2_POINTS))
                   && (cfg_log <= CFG_LOG2_W'(MAX_LOG2_POINTS));
  assign cfg_hs    = i_axi4s_cfg_tvalid & cfg_tready;
  assign cfg_ok    = cfg_hs & cfg_legal;

  // New frames are held off once the core holds its maximum.
  assign stall    = (in_cnt == '0) && (outst_q == OMAX);
  assign in_beat  = (run & core_tvalid & i_core_tready)
                  | (pad & i_core_tready);
  assign run_hs   = run & in_beat;
  assign in_end   = in_beat & in_last;

  assign out_beat = i_core_tvalid & (outst_q != '0);
  assign out_end  = out_beat & out_last;

  assign ext_i = DATAOUT_WIDTH'($signed(
    i_axi4s_data_tdata[DATAIN_WIDTH-1:0]));
  assign ext_q = DATAOUT_WIDTH'($signed(
    i_axi4s_data_tdata[2*DATAIN_WIDTH-1:DATAIN_WIDTH]));

  fft_bin_counter u_in_cnt (
    .i_aclk    (i_aclk),
    .i_aresetn (i_aresetn),
    .i_clr     (cfg_ok),
    .i_en      (in_beat),
    .i_lim     (lim),
    .o_cnt     (in_cnt),
    .o_last    (in_last)
  );

  fft_bin_counter u_out_cnt (
    .i_aclk    (i_aclk),
    .i_aresetn (i_aresetn),
    .i_clr     (cfg_ok),
    .i_en      (out_beat),
    .i_lim     (lim),
    .o_cnt     (out_cnt),
    .o_last    (out_last)
  );

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q <= UNCFG;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      UNCFG: if (cfg_ok) state_d = RUN;
      RUN: begin
`ifdef FFT_FRAME_CTRL_ZPAD_EN
        if (run_hs & i_axi4s_data_tlast & !in_last) state_d = PAD;
`endif
      end
`ifdef FFT_FRAME_CTRL_ZPAD_EN
      PAD: if (in_end) state_d = RUN;
`endif
      default: state_d = UNCFG;
    endcase
  end

  always_comb begin
    run         = 1'b0;
    pad         = 1'b0;
    cfg_tready  = 1'b0;
    data_tready = 1'b0;
    core_tvalid = 1'b0;
    unique case (state_q)
      UNCFG: cfg_tready = 1'b1;
      RUN: begin
        run         = 1'b1;
        data_tready = i_core_tready & !stall;
        core_tvalid = i_axi4s_data_tvalid & !stall;
        cfg_tready  = (in_cnt == '0) && (outst_q == '0)
                    && !(core_tvalid & i_core_tready);
      end
`ifdef FFT_FRAME_CTRL_ZPAD_EN
      PAD: begin
        pad         = 1'b1;
        core_tvalid = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    alm_set = '0;
    alm_set[ALM_EARLY] = run_hs & i_axi4s_data_tlast & !in_last;
    alm_set[ALM_MISS]  = run_hs & in_last & !i_axi4s_data_tlast;
    alm_set[ALM_CORE]  = i_core_tvalid
                       & ((outst_q == '0) | (i_core_tlast != out_last));
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      cfg_q       <= '0;
      stat_q      <= 1'b0;
      alm_q       <= '0;
      cfg_pulse_q <= 1'b0;
      outst_q     <= '0;
    end else begin
      cfg_pulse_q <= cfg_ok;
      if (cfg_ok) begin
        cfg_q  <= i_axi4s_cfg_tdata;
        stat_q <= 1'b1;
        alm_q  <= '0;
      end else begin
        alm_q  <= alm_q | alm_set;
      end
      if (in_end & !out_end) begin
        outst_q <= outst_q + OW'(1);
      end else if (!in_end & out_end) begin
        outst_q <= outst_q - OW'(1);
      end
    end
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      dv_q <= 1'b0;
      dd_q <= '0;
      dl_q <= 1'b0;
      du_q <= '0;
    end else begin
      dv_q <= i_core_tvalid;
      if (i_core_tvalid) begin
        dd_q <= i_core_tdata;
        dl_q <= out_last;
        du_q <= {{(TUSER_W-BIN_W-1){1'b0}}, cfg_q[CFG_INV_BIT], out_cnt};
      end
    end
  end

  // Ready is forced low while reset is held so every output reads 0.
  assign o_axi4s_cfg_tready  = cfg_tready & i_aresetn;
  assign o_axi4s_data_tready = data_tready;
  assign o_core_cfg_tvalid   = cfg_pulse_q;
  assign o_core_cfg_tdata    = cfg_q;
  assign o_core_tvalid       = core_tvalid;
  assign o_core_tdata        = run ? {ext_q, ext_i} : '0;
  assign o_core_tlast        = (run | pad) & in_last;
  assign o_axi4s_data_tvalid = dv_q;
  assign o_axi4s_data_tdata  = dd_q;
  assign o_axi4s_data_tlast  = dl_q;
  assign o_axi4s_data_tuser  = du_q;
  assign o_alm               = alm_q;
  assign o_stat              = stat_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed/randomized bench for fft_frame_ctrl.
// Build with +define+FFT_FRAME_CTRL_ZPAD_EN to cover zero padding.
module tb_fft_frame_ctrl;

  localparam int DI   = 16;
  localparam int DO   = 16;
  localparam int MAXL = 10;
  localparam int MAXO = 4;

  logic          i_aclk = 1'b0;
  logic          i_aresetn = 1'b0;
  logic          i_axi4s_cfg_tvalid = 1'b0;
  logic [7:0]    i_axi4s_cfg_tdata = '0;
  logic          o_axi4s_cfg_tready;
  logic          i_axi4s_data_tvalid = 1'b0;
  logic [2*DI-1:0] i_axi4s_data_tdata = '0;
  logic          i_axi4s_data_tlast = 1'b0;
  logic          o_axi4s_data_tready;
  logic          o_core_cfg_tvalid;
  logic [7:0]    o_core_cfg_tdata;
  logic          o_core_tvalid;
  logic [2*DO-1:0] o_core_tdata;
  logic          o_core_tlast;
  logic          i_core_tready = 1'b1;
  logic          i_core_tvalid = 1'b0;
  logic [2*DO-1:0] i_core_tdata = '0;
  logic          i_core_tlast = 1'b0;
  logic          o_axi4s_data_tvalid;
  logic [2*DO-1:0] o_axi4s_data_tdata;
  logic          o_axi4s_data_tlast;
  logic [23:0]   o_axi4s_data_tuser;
  logic [2:0]    o_alm;
  logic          o_stat;

  fft_frame_ctrl #(
    .DATAIN_WIDTH    (DI),
    .DATAOUT_WIDTH   (DO),
    .MAX_LOG2_POINTS (MAXL),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .i_aclk              (i_aclk),
    .i_aresetn           (i_aresetn),
    .i_axi4s_cfg_tvalid  (i_axi4s_cfg_tvalid),
    .i_axi4s_cfg_tdata   (i_axi4s_cfg_tdata),
    .o_axi4s_cfg_tready  (o_axi4s_cfg_tready),
    .i_axi4s_data_tvalid (i_axi4s_data_tvalid),
    .i_axi4s_data_tdata  (i_axi4s_data_tdata),
    .i_axi4s_data_tlast  (i_axi4s_data_tlast),
    .o_axi4s_data_tready (o_axi4s_data_tready),
    .o_core_cfg_tvalid   (o_core_cfg_tvalid),
    .o_core_cfg_tdata    (o_core_cfg_tdata),
    .o_core_tvalid       (o_core_tvalid),
    .o_core_tdata        (o_core_tdata),
    .o_core_tlast        (o_core_tlast),
    .i_core_tready       (i_core_tready),
    .i_core_tvalid       (i_core_tvalid),
    .i_core_tdata        (i_core_tdata),
    .i_core_tlast        (i_core_tlast),
    .o_axi4s_data_tvalid (o_axi4s_data_tvalid),
    .o_axi4s_data_tdata  (o_axi4s_data_tdata),
    .o_axi4s_data_tlast  (o_axi4s_data_tlast),
    .o_axi4s_data_tuser  (o_axi4s_data_tuser),
    .o_alm               (o_alm),
    .o_stat              (o_stat)
  );

  always #5 i_aclk = ~i_aclk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int         n_pts   = 0;
  bit         inv     = 1'b0;
  int         outst   = 0;
  logic [2:0] alm_exp = '0;
  logic [7:0] cfg_exp = '0;
  bit         stat_exp = 1'b0;
  bit         probe   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DO-1:0] sext(input logic [DI-1:0] v);
    longint s;
    s = longint'(v);
    if (v[DI-1]) s = s - (longint'(1) << DI);
    return DO'(s);
  endfunction

  task automatic do_cfg(input logic [7:0] w);
    bit legal;
    legal = (int'(w[4:0]) >= 3) && (int'(w[4:0]) <= MAXL);
    @(negedge i_aclk);
    i_axi4s_cfg_tvalid = 1'b1;
    i_axi4s_cfg_tdata  = w;
    #1;
    chk("cfg_tready", 64'(o_axi4s_cfg_tready), 64'(1));
    @(negedge i_aclk);
    i_axi4s_cfg_tvalid = 1'b0;
    if (legal) begin
      cfg_exp  = w;
      n_pts    = 1 << w[4:0];
      inv      = w[5];
      alm_exp  = '0;
      stat_exp = 1'b1;
    end
    #1;
    chk("cfg_pulse", 64'(o_core_cfg_tvalid), 64'(legal));
    chk("cfg_word", 64'(o_core_cfg_tdata), 64'(cfg_exp));
    chk("cfg_stat", 64'(o_stat), 64'(stat_exp));
    chk("cfg_alm", 64'(o_alm), 64'(alm_exp));
    @(negedge i_aclk);
    #1;
    chk("cfg_pulse_end", 64'(o_core_cfg_tvalid), 64'(0));
  endtask

  task automatic send_frame(input int n, input int early_at,
                            input bit stall, input int pause_at);
    int k = 0;
    int guard = 0;
    bit rdy;
    bit padding = 1'b0;
    bit paused = 1'b0;
    logic [2*DI-1:0] d;
    while (k < n && guard < 500) begin
      @(negedge i_aclk);
      guard++;
      if (probe) i_axi4s_cfg_tvalid = 1'b1;
      if (k == pause_at && !paused) begin
        paused = 1'b1;
        i_axi4s_data_tvalid = 1'b0;
        i_core_tready = 1'b1;
        #1;
        chk("cfg_block_mid", 64'(o_axi4s_cfg_tready), 64'(0));
        chk("idle_core_tvalid", 64'(o_core_tvalid), 64'(0));
      end else begin
        rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        d = (2*DI)'($urandom);
        i_core_tready       = rdy;
        i_axi4s_data_tvalid = 1'b1;
        i_axi4s_data_tdata  = d;
        i_axi4s_data_tlast  = (k == n-1) || (k == early_at);
        #1;
        if (probe) begin
          chk("cfg_block_frame", 64'(o_axi4s_cfg_tready), 64'(0));
          chk("cfg_no_pulse", 64'(o_core_cfg_tvalid), 64'(0));
        end
        if (padding) begin
          chk("pad_tready", 64'(o_axi4s_data_tready), 64'(0));
          chk("pad_tvalid", 64'(o_core_tvalid), 64'(1));
          chk("pad_tdata", 64'(o_core_tdata), 64'(0));
        end else begin
          chk("in_tready", 64'(o_axi4s_data_tready), 64'(rdy));
          chk("core_tvalid", 64'(o_core_tvalid), 64'(1));
          chk("core_tdata", 64'(o_core_tdata),
              64'({sext(d[2*DI-1:DI]), sext(d[DI-1:0])}));
        end
        chk("core_tlast", 64'(o_core_tlast), 64'(k == n-1));
        if (rdy) begin
`ifdef FFT_FRAME_CTRL_ZPAD_EN
          if (k == early_at) padding = 1'b1;
`endif
          k++;
        end
      end
    end
    if (guard >= 500) chk("frame_timeout", 64'(0), 64'(1));
    @(posedge i_aclk);
    #1;
    i_axi4s_data_tvalid = 1'b0;
    i_axi4s_data_tlast  = 1'b0;
    i_core_tready       = 1'b1;
    outst++;
    if (early_at >= 0) alm_exp[0] = 1'b1;
  endtask

  task automatic recv_frame(input int n, input bit stray);
    logic [2*DO-1:0] d;
    logic [23:0] u;
    int idx;
    for (int b = 0; b < n; b++) begin
      @(negedge i_aclk);
      d = (2*DO)'($urandom);
      i_core_tvalid = 1'b1;
      i_core_tdata  = d;
      i_core_tlast  = (b == n-1);
      #1;
      if (probe) chk("cfg_block_drain", 64'(o_axi4s_cfg_tready), 64'(0));
      @(posedge i_aclk);
      #1;
      idx = stray ? 0 : b;
      u = {7'd0, inv, 16'(idx)};
      chk("out_tvalid", 64'(o_axi4s_data_tvalid), 64'(1));
      chk("out_tdata", 64'(o_axi4s_data_tdata), 64'(d));
      chk("out_tuser", 64'(o_axi4s_data_tuser), 64'(u));
      chk("out_tlast", 64'(o_axi4s_data_tlast), 64'(idx == n_pts-1));
    end
    @(negedge i_aclk);
    i_core_tvalid = 1'b0;
    i_core_tlast  = 1'b0;
    @(posedge i_aclk);
    #1;
    chk("out_idle", 64'(o_axi4s_data_tvalid), 64'(0));
    if (stray) alm_exp[2] = 1'b1;
    else outst--;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cfg_tready"}, 64'(o_axi4s_cfg_tready), 64'(0));
    chk({tag, "_data_tready"}, 64'(o_axi4s_data_tready), 64'(0));
    chk({tag, "_core_cfg_v"}, 64'(o_core_cfg_tvalid), 64'(0));
    chk({tag, "_core_cfg_d"}, 64'(o_core_cfg_tdata), 64'(0));
    chk({tag, "_core_tvalid"}, 64'(o_core_tvalid), 64'(0));
    chk({tag, "_core_tdata"}, 64'(o_core_tdata), 64'(0));
    chk({tag, "_core_tlast"}, 64'(o_core_tlast), 64'(0));
    chk({tag, "_out_tvalid"}, 64'(o_axi4s_data_tvalid), 64'(0));
    chk({tag, "_out_tdata"}, 64'(o_axi4s_data_tdata), 64'(0));
    chk({tag, "_out_tlast"}, 64'(o_axi4s_data_tlast), 64'(0));
    chk({tag, "_out_tuser"}, 64'(o_axi4s_data_tuser), 64'(0));
    chk({tag, "_alm"}, 64'(o_alm), 64'(0));
    chk({tag, "_stat"}, 64'(o_stat), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // reset state
    #1;
    chk_all_zero("rst0");
    repeat (2) @(negedge i_aclk);
    i_aresetn = 1'b1;
    #1;
    chk("uncfg_cfg_tready", 64'(o_axi4s_cfg_tready), 64'(1));
    chk("uncfg_data_tready", 64'(o_axi4s_data_tready), 64'(0));
    chk("uncfg_stat", 64'(o_stat), 64'(0));

    // N=8 forward, clean frame and clean core return
    do_cfg(8'h03);
    send_frame(8, -1, 1'b0, -1);
    chk("alm_clean_in", 64'(o_alm), 64'(alm_exp));
    recv_frame(8, 1'b0);
    chk("alm_clean_out", 64'(o_alm), 64'(alm_exp));

    // random core back-pressure
    send_frame(8, -1, 1'b1, -1);
    recv_frame(8, 1'b0);
    chk("alm_stall", 64'(o_alm), 64'(alm_exp));

    // early upstream tlast on beat 5
    send_frame(8, 5, 1'b1, -1);
    chk("alm_early", 64'(o_alm), 64'(alm_exp));
    recv_frame(8, 1'b0);
    chk("alm_early_drain", 64'(o_alm), 64'(alm_exp));

    // core beat with nothing in flight
    recv_frame(1, 1'b1);
    chk("alm_stray", 64'(o_alm), 64'(alm_exp));

    // config held during a frame, accepted only after drain
    i_axi4s_cfg_tdata = 8'h24;
    probe = 1'b1;
    send_frame(8, -1, 1'b0, 3);
    @(negedge i_aclk);
    #1;
    chk("cfg_block_outst", 64'(o_axi4s_cfg_tready), 64'(0));
    recv_frame(8, 1'b0);
    probe = 1'b0;
    chk("cfg_late_pulse", 64'(o_core_cfg_tvalid), 64'(1));
    i_axi4s_cfg_tvalid = 1'b0;
    cfg_exp = 8'h24;
    n_pts   = 16;
    inv     = 1'b1;
    alm_exp = '0;
    chk("cfg_late_word", 64'(o_core_cfg_tdata), 64'(cfg_exp));
    chk("cfg_late_alm", 64'(o_alm), 64'(alm_exp));

    // illegal configs leave everything alone
    do_cfg(8'h1F);
    do_cfg(8'h02);
    do_cfg(8'h0B);
    send_frame(16, -1, 1'b1, -1);
    recv_frame(16, 1'b0);
    chk("alm_n16", 64'(o_alm), 64'(alm_exp));

    // fill the core, then the extra frame must stall
    do_cfg(8'h03);
    for (int f = 0; f < MAXO; f++) send_frame(8, -1, 1'b1, -1);
    @(negedge i_aclk);
    i_axi4s_data_tvalid = 1'b1;
    i_axi4s_data_tdata  = (2*DI)'($urandom);
    i_core_tready       = 1'b1;
    #1;
    chk("full_tready", 64'(o_axi4s_data_tready), 64'(outst < MAXO));
    chk("full_core_tvalid", 64'(o_core_tvalid), 64'(outst < MAXO));
    chk("full_cfg_tready", 64'(o_axi4s_cfg_tready), 64'(0));

    // one core beat, then asynchronous reset mid-cycle
    @(negedge i_aclk);
    i_axi4s_data_tvalid = 1'b0;
    i_core_tvalid = 1'b1;
    i_core_tdata  = (2*DO)'($urandom);
    i_core_tlast  = 1'b0;
    @(posedge i_aclk);
    #1;
    chk("pre_rst_tvalid", 64'(o_axi4s_data_tvalid), 64'(1));
    chk("pre_rst_stat", 64'(o_stat), 64'(1));
    chk("pre_rst_alm", 64'(o_alm), 64'(alm_exp));
    i_axi4s_data_tvalid = 1'b1;
    #1;
    i_aresetn = 1'b0;
    #1;
    chk_all_zero("rst1");
    i_core_tvalid = 1'b0;
    i_axi4s_data_tvalid = 1'b0;
    repeat (2) @(negedge i_aclk);
    i_aresetn = 1'b1;
    #1;
    chk("post_rst_cfg_tready", 64'(o_axi4s_cfg_tready), 64'(1));
    chk("post_rst_stat", 64'(o_stat), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
